// File: rtl/periph_bus_master_if.sv
// Peripheral register bus: address, strobes and acknowledge.
// The shared data lines are a tri-state net and stay a plain inout port on the master.
interface periph_bus_master_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  read;
    logic                  write;
    logic                  ready;

    modport master (output addr, output read, output write, input ready);
    modport slave  (input addr, input read, input write, output ready);
endinterface

// File: rtl/periph_bus_master.sv
// Peripheral bus initiator. It runs one SETUP/STROBE/DONE transaction per CPU request.
// A transaction that waits too long for ready ends with an error completion.
module periph_bus_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    periph_bus_master_if.master   bus,
    inout  wire  [DATA_WIDTH-1:0] data
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    // Counter value seen in the last allowed STROBE cycle
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [7:0]            cnt_q;
    logic                  accept;
    logic                  timed_out;
    logic                  drive_en;

    assign accept    = (state_q == IDLE) && req;
    assign timed_out = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: ready takes priority over the timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (bus.ready || timed_out) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, wait counter, read capture and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                we_q    <= we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                err_q   <= 1'b0;
            end
            if (state_q == STROBE) begin
                if (bus.ready) begin
                    if (!we_q) rdata_q <= data;
                end else if (timed_out) begin
                    err_q <= 1'b1;
                    if (!we_q) rdata_q <= '1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
            if (state_q == DONE) cnt_q <= '0;
        end
    end

    // Strobes and bus enable decode from state, so an async reset drops them at once
    assign drive_en  = we_q && ((state_q == SETUP) || (state_q == STROBE));
    assign data      = drive_en ? wdata_q : 'z;
    assign bus.addr  = addr_q;
    assign bus.read  = (state_q == STROBE) && !we_q;
    assign bus.write = (state_q == STROBE) && we_q;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign cpu_rdata = rdata_q;
endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- Initiator side of the peripheral register bus (addr / data / read / write / ready).
- Takes single-word requests from the CPU load/store path and runs one bus transaction per request.
- Drives the shared tri-state data bus only during writes and captures read data when the addressed peripheral raises ready.
- Enforces a bounded wait: a peripheral that never answers ends the transaction with an error flag instead of hanging the CPU.

Parameters:
- DATA_WIDTH, 32: width of the peripheral data bus and the CPU data ports.
- ADDR_WIDTH, 8: width of the peripheral register address.
- TIMEOUT_CYCLES, 16: maximum STROBE cycles without ready before an error completion (range 1..255).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  CPU request; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- cpu_addr  input  ADDR_WIDTH  target register address; sampled with req.
- cpu_wdata  input  DATA_WIDTH  write data; sampled with req.
- cpu_rdata  output  DATA_WIDTH  read data; valid from the done cycle until the next done.
- busy  output  1  high from the cycle after req is accepted through the DONE cycle.
- done  output  1  one-cycle completion pulse.
- err  output  1  timeout flag; valid with done, held until the next accepted req.
- addr  output  ADDR_WIDTH  peripheral bus address.
- data  inout  DATA_WIDTH  peripheral bus data; tri-state when not writing.
- read  output  1  read strobe.
- write  output  1  write strobe.
- ready  input  1  peripheral acknowledge.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state = IDLE; read = write = busy = done = err = 0.
  - addr = 0, cpu_rdata = 0, timeout counter = 0, data = Z.
  - These hold immediately, including mid-transaction; no partial strobe survives reset.
- State machine: IDLE -> SETUP -> STROBE -> DONE -> IDLE.
- IDLE:
  - On req=1 at a clock edge, latch cpu_addr, cpu_wdata, we; clear err; go to SETUP.
  - req=0: stay in IDLE.
- SETUP (exactly 1 cycle):
  - addr driven with the latched address.
  - data driven with the latched wdata if we=1, Z otherwise.
  - read = write = 0; go to STROBE.
- STROBE:
  - Assert write (we=1) or read (we=0); never both. Address and write data stay stable.
  - Counter increments each STROBE cycle.
  - At an edge with ready=1: on a read, capture data into cpu_rdata; go to DONE with err=0.
  - Else, when the counter reaches TIMEOUT_CYCLES: go to DONE with err=1; on a read, set cpu_rdata to all ones.
  - If ready and timeout coincide, ready wins (err=0).
- DONE (1 cycle):
  - Strobes deasserted; done=1; data = Z; counter cleared; go to IDLE.
  - A ready still high in DONE or IDLE is ignored.
- Latency (ready answered in the first STROBE cycle):
  - req accepted at edge 0; SETUP in cycle 1; STROBE in cycle 2; done in cycle 3.
  - Minimum request-to-request period is 4 cycles.
- busy = (state != IDLE). req while busy is ignored, neither queued nor latched.
- Tri-state rule: data is driven only in SETUP and STROBE of a write; Z in every other state and under reset.
- addr holds its last value in IDLE.
- cpu_rdata is unchanged by write transactions.

Test Plan:
- Write: req=1, we=1, cpu_addr=8'h03, cpu_wdata=32'h8000_00A5; ready model answers in STROBE cycle 1.
  -> data bus = 32'h8000_00A5 in SETUP and STROBE; write high for 1 cycle; done pulse in cycle 3; err=0; data=Z afterwards.
- Read: responder drives 32'hFFFF_FFFF at addr 8'h00 with ready after 3 STROBE cycles.
  -> read high 3 cycles; cpu_rdata=32'hFFFF_FFFF at done; busy high for 5 cycles.
- Timeout: read with ready tied 0, TIMEOUT_CYCLES=16.
  -> read high for exactly 16 cycles; done with err=1; cpu_rdata=32'hFFFF_FFFF.
  -> next successful request clears err.
- Ready coincides with timeout: ready=1 on the 16th STROBE cycle.
  -> err=0; data captured.
- req pulses during busy, including with different addr/we values.
  -> ignored; the original transaction completes unchanged; no second done.
- rst_n=0 asynchronously mid-STROBE of a write.
  -> write=0 and data=Z without waiting for a clock edge; after release, busy=0 and the next req completes normally.
